// File: rtl/nios_pio_in_capture.sv
// nios_pio_in_capture
//   Avalon-MM slave input PIO. Synchronises and debounces an external input bus,
//   latches selected edges of the debounced levels into a sticky edge-capture
//   register and raises a level interrupt while any unmasked captured edge is pending.
//
//   Register map (word addresses):
//     0 DATA     read-only, debounced input level
//     1 reserved reads 0, writes ignored
//     2 IRQMASK  read/write
//     3 EDGECAP  read, write-1-to-clear per bit
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   address     word address
//   chipselect  slave select
//   read_n      active-low read strobe
//   write_n     active-low write strobe
//   writedata   write data
//   in_port     asynchronous external inputs
//   readdata    registered read data, zero-extended above WIDTH
//   irq         level interrupt, |(edgecap & mask)
module nios_pio_in_capture #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]           sync1_q, sync2_q;
  logic [WIDTH-1:0]           filt_q, filt_d;
  logic [WIDTH-1:0]           filt_dly_q;
  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]           mask_q, mask_d;
  logic [WIDTH-1:0]           edgecap_q, edgecap_d;
  logic [WIDTH-1:0]           edge_det;
  logic [WIDTH-1:0]           clr;
  logic [31:0]                readdata_q, readdata_d;
  logic                       wr_en, rd_en;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  // Upper write-data bits have no destination when WIDTH < 32.
  if (WIDTH < 32) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^writedata[31:WIDTH];
  end

  // Per-bit debounce: a level change is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement; any agreeing cycle restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    if (EDGE_TYPE == 0) begin
      edge_det = filt_q & ~filt_dly_q;
    end else if (EDGE_TYPE == 1) begin
      edge_det = ~filt_q & filt_dly_q;
    end else begin
      edge_det = filt_q ^ filt_dly_q;
    end
  end

  always_comb begin
    mask_d = mask_q;
    clr    = '0;
    if (wr_en && address == 2'd2) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      clr = writedata[WIDTH-1:0];
    end
    // A newly detected edge beats a simultaneous clear.
    edgecap_d = (edgecap_q & ~clr) | edge_det;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (rd_en) begin
      unique case (address)
        2'd0:    readdata_d = 32'(filt_q);
        2'd2:    readdata_d = 32'(mask_q);
        2'd3:    readdata_d = 32'(edgecap_q);
        default: readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      filt_q     <= '0;
      filt_dly_q <= '0;
      cnt_q      <= '0;
      mask_q     <= '0;
      edgecap_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      mask_q     <= mask_d;
      edgecap_q  <= edgecap_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  // Registers only, so no combinational path from the bus to irq.
  assign irq      = |(edgecap_q & mask_q);

endmodule

// File: tb/tb_nios_pio_in_capture.sv
// Bench for nios_pio_in_capture: two instances (rising and falling edge capture)
// share one bus and input stimulus; a window-based model predicts both.
module tb_nios_pio_in_capture;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, read_n, write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_r, rd_f;
  logic        irq_r, irq_f;
  logic        cmp_en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nios_pio_in_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_r), .irq(irq_r)
  );

  nios_pio_in_capture #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_f), .irq(irq_f)
  );

  // ---------------- model ----------------
  // past[0] is the in_port sample from the previous edge, past[j] j edges earlier.
  logic [7:0]  past [0:D];
  logic [7:0]  filt_m, filtp_m, mask_m;
  logic [7:0]  ecap_m [2];
  logic [31:0] rdata_m [2];
  logic [7:0]  clr_m;

  assign clr_m = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;

  // A filtered bit flips once the last D synchronised samples all disagree with it.
  function automatic logic [7:0] filt_next();
    logic [7:0] nf;
    nf = filt_m;
    for (int b = 0; b < 8; b++) begin
      logic agree;
      agree = 1'b0;
      for (int j = 1; j <= D; j++) if (past[j][b] == filt_m[b]) agree = 1'b1;
      if (!agree) nf[b] = ~filt_m[b];
    end
    return nf;
  endfunction

  function automatic logic [31:0] reg_val(input int e, input logic [1:0] a);
    case (a)
      2'd0:    return {24'h0, filt_m};
      2'd2:    return {24'h0, mask_m};
      2'd3:    return {24'h0, ecap_m[e]};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j <= D; j++) past[j] <= 8'h00;
      filt_m     <= 8'h00;
      filtp_m    <= 8'h00;
      mask_m     <= 8'h00;
      ecap_m[0]  <= 8'h00;
      ecap_m[1]  <= 8'h00;
      rdata_m[0] <= 32'h0;
      rdata_m[1] <= 32'h0;
    end else begin
      if (chipselect && !read_n) begin
        rdata_m[0] <= reg_val(0, address);
        rdata_m[1] <= reg_val(1, address);
      end
      ecap_m[0] <= (ecap_m[0] & ~clr_m) | (filt_m & ~filtp_m);
      ecap_m[1] <= (ecap_m[1] & ~clr_m) | (~filt_m & filtp_m);
      if (chipselect && !write_n && address == 2'd2) mask_m <= writedata[7:0];
      filtp_m <= filt_m;
      filt_m  <= filt_next();
      past[0] <= in_port;
      for (int j = 1; j <= D; j++) past[j] <= past[j-1];
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_rdata_rise", rd_r, rdata_m[0]);
      check("cyc_rdata_fall", rd_f, rdata_m[1]);
      check("cyc_irq_rise", {31'h0, irq_r}, {31'h0, |(ecap_m[0] & mask_m)});
      check("cyc_irq_fall", {31'h0, irq_f}, {31'h0, |(ecap_m[1] & mask_m)});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    tick();
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 2'd0; writedata = 32'h0; in_port = 8'h00; cmp_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    cmp_en = 1'b1;
    check("reset_rdata", rd_r, 32'h0);
    check("reset_irq", {31'h0, irq_r}, 32'h0);
    reset = 1'b0;
    tick(); tick();
    bus_read(2);
    check("reset_mask", rd_r, 32'h0);
    bus_write(2, 32'hFF);

    // Debounce latency: 0x00 -> 0x05, filt changes at edge 6, edgecap at edge 7.
    in_port = 8'h05;
    repeat (5) tick();
    check("irq_edge5", {31'h0, irq_r}, 32'h0);
    chipselect = 1'b1; read_n = 1'b0; address = 2'd0;
    tick();
    check("data_edge6", rd_r, 32'h00);
    check("irq_edge6", {31'h0, irq_r}, 32'h0);
    tick();
    check("data_edge7", rd_r, 32'h05);
    check("irq_edge7", {31'h0, irq_r}, 32'h1);
    chipselect = 1'b0; read_n = 1'b1;
    bus_read(3);
    check("ecap_rise", rd_r, 32'h05);
    check("ecap_fall_none", rd_f, 32'h00);
    bus_write(3, 32'hFF);
    check("irq_cleared", {31'h0, irq_r}, 32'h0);

    // Glitch of 3 cycles on bit 3 must be rejected.
    in_port = 8'h0D;
    repeat (3) tick();
    in_port = 8'h05;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("glitch_irq", {31'h0, irq_r | irq_f}, 32'h0);
    end
    bus_read(0);
    check("glitch_data", rd_r, 32'h05);
    bus_read(3);
    check("glitch_ecap", rd_r | rd_f, 32'h00);

    // Clear versus set race on bit 0.
    in_port = 8'h04;
    repeat (8) tick();
    bus_write(3, 32'hFF);
    in_port = 8'h05;
    repeat (8) tick();
    check("race_pre_irq", {31'h0, irq_r}, 32'h1);
    in_port = 8'h04;
    repeat (8) tick();
    in_port = 8'h05;
    repeat (6) tick();
    bus_write(3, 32'h01);       // lands on the edge where the new rise is captured
    check("race_irq", {31'h0, irq_r}, 32'h1);
    bus_read(3);
    check("race_ecap_rise", rd_r, 32'h01);
    check("race_ecap_fall", rd_f, 32'h00);
    bus_write(3, 32'h01);
    check("race_clear_irq", {31'h0, irq_r}, 32'h0);
    bus_read(3);
    check("race_clear_ecap", rd_r, 32'h00);

    // Masking and falling-edge capture on bit 2.
    bus_write(2, 32'h00);
    bus_write(3, 32'hFF);
    in_port = 8'h01;
    repeat (8) tick();
    check("masked_irq", {31'h0, irq_f}, 32'h0);
    bus_read(3);
    check("fall_ecap", rd_f, 32'h04);
    check("fall_ecap_rise_dut", rd_r, 32'h00);
    bus_write(2, 32'h04);
    check("unmask_irq", {31'h0, irq_f}, 32'h1);
    check("unmask_irq_rise_dut", {31'h0, irq_r}, 32'h0);
    bus_write(1, 32'hFFFF_FFFF);
    bus_write(0, 32'hFFFF_FFFF);
    bus_read(1);
    check("reserved_read", rd_f, 32'h0);
    bus_read(0);
    check("data_after_ro_write", rd_r, 32'h01);
    bus_read(2);
    check("mask_read", rd_f, 32'h04);

    // Reset in the middle of a debounce.
    in_port = 8'h00;
    repeat (8) tick();
    bus_write(3, 32'hFF);
    bus_read(2);
    in_port = 8'h80;
    repeat (2) tick();
    #3 reset = 1'b1;
    #1;
    check("async_rst_rdata", rd_f, 32'h0);
    check("async_rst_irq", {31'h0, irq_r | irq_f}, 32'h0);
    repeat (3) tick();
    check("held_rst_rdata", rd_r | rd_f, 32'h0);
    reset = 1'b0;
    repeat (5) tick();
    bus_read(0);
    check("rst_data_edge6", rd_r, 32'h00);
    bus_read(0);
    check("rst_data_edge7", rd_r, 32'h80);
    bus_read(3);
    check("rst_ecap_rise", rd_r, 32'h80);
    check("rst_ecap_fall", rd_f, 32'h00);
    bus_read(2);
    check("rst_mask", rd_r, 32'h00);
    check("rst_irq_masked", {31'h0, irq_r}, 32'h0);
    bus_write(2, 32'h80);
    check("rst_irq_unmasked", {31'h0, irq_r}, 32'h1);

    repeat (2) tick();
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
